// File: rtl/cpu_header_extract_pkg.sv
// Shared definitions for the CPU header extractor: FSM encoding, header length
// limits and a saturating counter helper.
package cpu_header_extract_pkg;

  typedef enum logic {
    HDR_S = 1'b0,
    PAY_S = 1'b1
  } state_e;

  localparam int HDR_BEATS_MIN = 1;
  localparam int HDR_BEATS_MAX = 4;
  // Wide enough to index every legal header slot
  localparam int HDR_CNT_W     = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_header_extract_if.sv
// AXI-Stream bundle used for both the ingress and the egress side of the
// header extractor; tuser is only meaningful on the egress side.
interface cpu_header_extract_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 256
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;
  logic [USER_W-1:0]   tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cpu_header_extract_skid_buf.sv
// Two-entry registered skid buffer: output valid one cycle after a push,
// in_ready depends only on local state so a full beat per cycle is sustained.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    in_ready = (cnt_q != 2'd2);
    push     = in_valid & in_ready;
    pop      = (cnt_q != 2'd0) & out_ready;
    main_d   = main_q;
    skid_d   = skid_q;
    cnt_d    = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          main_d = in_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d = in_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a pop can happen
        if (pop) begin
          main_d = skid_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = (cnt_q != 2'd0);

endmodule

// File: rtl/cpu_header_extract.sv
// Strips a HDR_BEATS-beat CPU header off each frame and presents it as tuser
// on the payload beats. Define CPU_HDR_STATS_EN to add frame/runt counters.
module cpu_header_extract
  import cpu_header_extract_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 256,
  parameter int HDR_BEATS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_header_extract_if.slave   s_axis,
  cpu_header_extract_if.master  m_axis,
  output logic                  drop_pulse
`ifdef CPU_HDR_STATS_EN
  ,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           drop_cnt
`endif
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;
  localparam int HDR_W  = HDR_BEATS * C_DATA_WIDTH;
  localparam int PKT_W  = C_TUSER_WIDTH + 1 + KEEP_W + C_DATA_WIDTH;
  localparam logic [HDR_CNT_W-1:0] LAST_SLOT = HDR_CNT_W'(HDR_BEATS - 1);

  if (HDR_BEATS < HDR_BEATS_MIN || HDR_BEATS > HDR_BEATS_MAX ||
      C_TUSER_WIDTH > HDR_W || (C_DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("cpu_header_extract: illegal parameter combination");
  end

  state_e                 state_q, state_d;
  logic [HDR_CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [HDR_W-1:0]       stage_q, stage_d;
  logic [HDR_W-1:0]       hdr_next;
  logic [C_TUSER_WIDTH-1:0] hdr_q, hdr_d;
  logic                   drop_q, drop_d;
  logic                   in_ready, skid_in_valid, skid_ready;
  logic [PKT_W-1:0]       skid_out;

  // Partial headers live in a staging register so a runt never disturbs the
  // tuser of the previous good frame.
  for (genvar gi = 0; gi < HDR_BEATS; gi++) begin : g_slot
    assign hdr_next[gi*C_DATA_WIDTH +: C_DATA_WIDTH] =
      (hdr_cnt_q == HDR_CNT_W'(gi)) ? s_axis.tdata : stage_q[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    stage_d       = stage_q;
    hdr_d         = hdr_q;
    drop_d        = 1'b0;
    in_ready      = 1'b0;
    skid_in_valid = 1'b0;
    case (state_q)
      HDR_S: begin
        in_ready = 1'b1;
        if (s_axis.tvalid) begin
          if (s_axis.tlast) begin
            drop_d    = 1'b1;
            hdr_cnt_d = '0;
          end else if (hdr_cnt_q == LAST_SLOT) begin
            hdr_d     = hdr_next[C_TUSER_WIDTH-1:0];
            hdr_cnt_d = '0;
            state_d   = PAY_S;
          end else begin
            stage_d   = hdr_next;
            hdr_cnt_d = hdr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        in_ready      = skid_ready;
        skid_in_valid = s_axis.tvalid;
        if (s_axis.tvalid && skid_ready && s_axis.tlast) state_d = HDR_S;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HDR_S;
      hdr_cnt_q <= '0;
      stage_q   <= '0;
      hdr_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      stage_q   <= stage_d;
      hdr_q     <= hdr_d;
      drop_q    <= drop_d;
    end
  end

  assign s_axis.tready = in_ready & ~rst;
  assign drop_pulse    = drop_q;

  axis_skid_buf #(.WIDTH(PKT_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({hdr_q, s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tdata = skid_out[C_DATA_WIDTH-1:0];
  assign m_axis.tkeep = skid_out[C_DATA_WIDTH +: KEEP_W];
  assign m_axis.tlast = skid_out[C_DATA_WIDTH + KEEP_W];
  assign m_axis.tuser = skid_out[PKT_W-1 -: C_TUSER_WIDTH];

  logic unused_ok;
  assign unused_ok = ^{s_axis.tuser, hdr_next};

`ifdef CPU_HDR_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (m_axis.tvalid && m_axis.tready && m_axis.tlast) frame_cnt_d = sat_inc(frame_cnt_q);
    if (drop_d) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_header_extract.sv
// Directed bench for cpu_header_extract with a two-beat 32-bit header; the
// counter checks are active when CPU_HDR_STATS_EN is defined.
module tb_cpu_header_extract;

  localparam int W  = 32;
  localparam int UW = 64;
  localparam int HB = 2;
  localparam int KW = W / 8;

  typedef struct packed {
    logic [UW-1:0] user;
    logic          last;
    logic [KW-1:0] keep;
    logic [W-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop_pulse;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  cpu_header_extract_if #(.DATA_W(W), .USER_W(UW)) s_if ();
  cpu_header_extract_if #(.DATA_W(W), .USER_W(UW)) m_if ();

`ifdef CPU_HDR_STATS_EN
  logic [31:0] frame_cnt, drop_cnt;
`endif

  cpu_header_extract #(
    .C_DATA_WIDTH (W),
    .C_TUSER_WIDTH(UW),
    .HDR_BEATS    (HB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .drop_pulse (drop_pulse)
`ifdef CPU_HDR_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  int    vec_cnt  = 0;
  int    miss_cnt = 0;
  int    cyc      = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    egress_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    assert (got === exp) else begin
      miss_cnt++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Egress monitor: captures handshakes and checks that a stalled beat holds
  beat_t cur_beat;
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    cur_beat = {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
    if (prev_stall && !rst) begin
      chk("hold_valid", 128'(m_if.tvalid), 128'(1'b1));
      chk("hold_beat", 128'(cur_beat), 128'(prev_beat));
    end
    if (m_if.tvalid && m_if.tready && !rst) begin
      got_q.push_back(cur_beat);
      egress_cyc.push_back(cyc);
    end
    prev_stall <= m_if.tvalid && !m_if.tready && !rst;
    prev_beat  <= cur_beat;
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_if.tready = ($urandom_range(0, 1) == 1);
      else          m_if.tready = 1'b1;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic last);
    int   n;
    logic ok;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.tvalid = 1'b0;
    chk("send_accept", 128'(ok), 128'(1'b1));
  endtask

  task automatic expect_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                             input logic last, input logic [UW-1:0] u);
    beat_t b;
    b = {u, last, k, d};
    exp_q.push_back(b);
  endtask

  task automatic frame(input logic [W-1:0] h0, input logic [W-1:0] h1,
                       input int n, input logic [W-1:0] base);
    send(h0, '1, 1'b0);
    send(h1, '1, 1'b0);
    for (int i = 0; i < n; i++) begin
      send(base + W'(i), '1, (i == n - 1));
      expect_beat(base + W'(i), '1, (i == n - 1), {h1, h0});
    end
  endtask

  task automatic check_out(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    egress_cyc.delete();
  endtask

  initial begin
    int c0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 128'(s_if.tready), 128'(1'b0));
    chk("rst_m_tvalid", 128'(m_if.tvalid), 128'(1'b0));
    chk("rst_m_tuser", 128'(m_if.tuser), 128'(0));
    chk("rst_m_tdata", 128'(m_if.tdata), 128'(0));
    chk("rst_m_tlast_keep", 128'({m_if.tlast, m_if.tkeep}), 128'(0));
    chk("rst_drop", 128'(drop_pulse), 128'(1'b0));
    rst = 1'b0;

    // Two-beat header, three payload beats, middle one with zero tkeep
    send(32'h1111_1111, '1, 1'b0);
    send(32'h2222_2222, '1, 1'b0);
    send(32'hCAFE_0000, 4'hF, 1'b0);
    send(32'hCAFE_0001, 4'h0, 1'b0);
    send(32'hCAFE_0002, 4'h3, 1'b1);
    expect_beat(32'hCAFE_0000, 4'hF, 1'b0, 64'h2222_2222_1111_1111);
    expect_beat(32'hCAFE_0001, 4'h0, 1'b0, 64'h2222_2222_1111_1111);
    expect_beat(32'hCAFE_0002, 4'h3, 1'b1, 64'h2222_2222_1111_1111);
    check_out("hdr2");

    // Runt on first header beat, runt on last header beat, then a good frame
    send(32'h0000_DEAD, '1, 1'b1);
    chk("runt0_drop_hi", 128'(drop_pulse), 128'(1'b1));
    @(posedge clk);
    #1;
    chk("runt0_drop_lo", 128'(drop_pulse), 128'(1'b0));
    send(32'h0000_BEEF, '1, 1'b0);
    send(32'h0000_F00D, '1, 1'b1);
    chk("runt1_drop_hi", 128'(drop_pulse), 128'(1'b1));
    @(posedge clk);
    #1;
    chk("runt1_drop_lo", 128'(drop_pulse), 128'(1'b0));
    send(32'h0000_0033, '1, 1'b0);
    send(32'h0000_0044, '1, 1'b0);
    send(32'h0000_0055, '1, 1'b1);
    expect_beat(32'h0000_0055, '1, 1'b1, 64'h0000_0044_0000_0033);
    check_out("runt");
`ifdef CPU_HDR_STATS_EN
    chk("stats_drop2", 128'(drop_cnt), 128'(2));
    chk("stats_frame2", 128'(frame_cnt), 128'(2));
`endif

    // 64-beat payload under continuous ready: latency and rate
    send(32'h0000_00A1, '1, 1'b0);
    send(32'h0000_00B1, '1, 1'b0);
    send(32'h5000_0000, '1, 1'b0);
    expect_beat(32'h5000_0000, '1, 1'b0, 64'h0000_00B1_0000_00A1);
    chk("lat1_valid", 128'(m_if.tvalid), 128'(1'b1));
    chk("lat1_data", 128'(m_if.tdata), 128'(32'h5000_0000));
    c0 = cyc;
    for (int i = 1; i < 64; i++) begin
      send(32'h5000_0000 + W'(i), '1, (i == 63));
      expect_beat(32'h5000_0000 + W'(i), '1, (i == 63), 64'h0000_00B1_0000_00A1);
    end
    chk("in_rate", 128'(cyc - c0), 128'(63));
    repeat (3) @(posedge clk);
    #1;
    chk("out_beats", 128'(egress_cyc.size()), 128'(64));
    if (egress_cyc.size() == 64)
      chk("out_rate", 128'(egress_cyc[63] - egress_cyc[0]), 128'(63));
    check_out("burst64");

    // Reset on payload beat 2 of 5
    send(32'h0000_0066, '1, 1'b0);
    send(32'h0000_0077, '1, 1'b0);
    send(32'h0000_0100, '1, 1'b0);
    send(32'h0000_0101, '1, 1'b0);
    expect_beat(32'h0000_0100, '1, 1'b0, 64'h0000_0077_0000_0066);
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", 128'(m_if.tvalid), 128'(1'b0));
    chk("midrst_s_tready", 128'(s_if.tready), 128'(1'b0));
    chk("midrst_m_tdata", 128'(m_if.tdata), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef CPU_HDR_STATS_EN
    chk("midrst_frame_cnt", 128'(frame_cnt), 128'(0));
    chk("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
    frame(32'h0000_0088, 32'h0000_0099, 2, 32'h0000_0200);
    check_out("after_rst");

    // 100 back-to-back frames with random egress backpressure
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++)
      frame(32'hA000_0000 | W'(f), 32'hB000_0000 | W'(f), 1 + (f % 3), 32'hD000_0000 | W'(f << 8));
    check_out("rand100");
    rand_rdy = 1'b0;
`ifdef CPU_HDR_STATS_EN
    chk("stats_frame100", 128'(frame_cnt), 128'(100));
    chk("stats_drop0", 128'(drop_cnt), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_header_extract.md
CPU_HEADER_EXTRACT -- requirements
Module: cpu_header_extract

Interface
REQ-001 Parameter C_DATA_WIDTH, default 256, AXIS data width in bits (multiple of 8).
REQ-002 Parameter C_TUSER_WIDTH, default 256, sideband width; SHALL be <= HDR_BEATS*C_DATA_WIDTH.
REQ-003 Parameter HDR_BEATS, default 1, CPU header length in beats, legal range 1..4.
REQ-004 Port clk  in  1  clock; all logic rising-edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports s_axis_tdata/tkeep/tvalid/tlast  in  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  ingress stream, header first.
REQ-007 Port s_axis_tready  out  1  ingress backpressure.
REQ-008 Ports m_axis_tdata/tkeep/tvalid/tlast  out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  payload-only egress stream.
REQ-009 Port m_axis_tuser  out  C_TUSER_WIDTH  extracted header, constant for all beats of a frame.
REQ-010 Port m_axis_tready  in  1  egress backpressure.
REQ-011 Port drop_pulse  out  1  one-cycle strobe per discarded runt frame.

Function
REQ-012 FSM states: HDR_S (collect header), PAY_S (forward payload); reset state HDR_S.
REQ-013 HDR_S: s_axis_tready=1; each accepted beat stored into header register slot hdr_cnt; no egress beat produced.
REQ-014 Header register is HDR_BEATS*C_DATA_WIDTH wide; beat 0 occupies LSBs; m_axis_tuser = its low C_TUSER_WIDTH bits.
REQ-015 HDR_S -> PAY_S when beat hdr_cnt==HDR_BEATS-1 accepted with tlast=0; hdr_cnt returns to 0.
REQ-016 Runt: tlast=1 on any header beat (including the last) -> frame discarded, drop_pulse=1 the following cycle, stay HDR_S, hdr_cnt=0, tuser unchanged.
REQ-017 PAY_S: s_axis_tready = egress stage can accept; accepted beats pass tdata/tkeep/tlast unmodified.
REQ-018 PAY_S -> HDR_S on acceptance of an ingress beat with tlast=1.
REQ-019 Egress is registered via a 2-entry skid buffer: latency 1 cycle ingress-accept to m_axis_tvalid; full throughput (1 beat/cycle) under continuous tready.
REQ-020 m_axis_tvalid once asserted SHALL hold with stable data/tuser until m_axis_tready=1.
REQ-021 tuser travels with each buffered beat; header capture of frame N+1 SHALL NOT alter tuser of frame N beats still in the buffer.
REQ-022 Back-to-back frames: first header beat of frame N+1 accepted the cycle after tlast of frame N; no bubble required.
REQ-023 tkeep not interpreted; zero-tkeep payload beats forwarded as-is.

Reset
REQ-024 On rst: state=HDR_S, hdr_cnt=0, header register=0, skid buffer emptied, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tdata/tkeep/tlast=0, drop_pulse=0, s_axis_tready=0 while rst high.
REQ-025 Reset mid-frame discards the partial frame; first beat after release is treated as header beat 0.

Configuration
REQ-026 Macro CPU_HDR_STATS_EN defined: adds outputs frame_cnt (out, 32) counting frames whose tlast left egress, and drop_cnt (out, 32) counting runts; both saturate at 0xFFFFFFFF, reset to 0.
REQ-027 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package holds state encoding constants (HDR_S, PAY_S) and the HDR_BEATS range limits.
REQ-029 Skid buffer is a separate sub-module axis_skid_buf (parametrised data+tuser+tkeep+tlast width).

Verification
REQ-030 HDR_BEATS=1: frame of 4 beats, header 0xA5 -> 3 egress beats, tuser=0xA5 on each, tlast on beat 3.
REQ-031 HDR_BEATS=2, C_TUSER_WIDTH=512: header beats H0,H1 -> tuser={H1,H0}; payload unchanged.
REQ-032 HDR_BEATS=2, 1-beat frame with tlast then valid 3-beat frame -> drop_pulse once, only 1 egress beat with the second frame's header; drop_cnt=1 with CPU_HDR_STATS_EN.
REQ-033 Random m_axis_tready 50% over 100 back-to-back frames -> no beat lost/duplicated, tuser per frame correct, frame_cnt=100.
REQ-034 rst asserted on payload beat 2 of 5 -> m_axis_tvalid=0 immediately; next frame after release extracted correctly.
REQ-035 Continuous tready, 64-beat frames -> egress 1 beat/cycle, first payload output 1 cycle after acceptance.
